// File: rtl/prcoder_rr.sv
// prcoder_rr: sequential priority encoder with a pending register, fixed-priority or
// round-robin arbitration, and a registered valid/ready code output.
module prcoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_mode,
  input  logic         i_flush,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_code,
  output logic [N-1:0] o_grant,
  output logic         o_busy
);
  logic [N-1:0] r_pending, r_grant;
  logic [W-1:0] r_code, r_ptr;
  logic         r_valid;
  logic         w_load, w_hit;
  logic [N-1:0] w_below, w_masked, w_clr;
  logic [W-1:0] w_win_all, w_win_low, w_win;
  always_comb begin
    for (int i = 0; i < N; i++) w_below[i] = W'(i) < r_ptr;
  end
  assign w_masked = r_pending & w_below;
  always_comb begin
    w_win_all = '0;
    w_win_low = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) w_win_all = W'(i);
      if (w_masked[i]) w_win_low = W'(i);
    end
  end
  // Round-robin: highest index below the last grant first, then wrap to the top.
  assign w_win  = (i_mode && |w_masked) ? w_win_low : w_win_all;
  assign w_load = !r_valid || i_ready;
  assign w_hit  = w_load && |r_pending;
  assign w_clr  = w_hit ? N'(1) << w_win : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_grant   <= '0;
      r_code    <= '0;
      r_ptr     <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_pending <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | i_req;
      if (w_load) begin
        r_valid <= |r_pending;
        r_grant <= w_clr;
      end
      if (w_hit) r_code <= w_win;
      if (w_hit && i_mode) r_ptr <= w_win;
    end
  end
  assign o_valid = r_valid;
  assign o_code  = r_code;
  assign o_grant = r_grant;
  assign o_busy  = |r_pending | r_valid;
endmodule
